// File: rtl/accumulator_bank_if.sv
// Accumulator bank bus: controller-side request signals and bank-side status.
// master = controller (drives select/ops/ALU result), slave = accumulator bank.
interface accumulator_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_W      = 2
);
  logic [SEL_W-1:0]      acc_sel;
  logic                  ld_ac;
  logic                  clr_ac;
  logic [DATA_WIDTH-1:0] ac_in;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] ac_out;
  logic                  zero_flag;
  logic                  neg_flag;
  logic                  stk_empty;
  logic                  stk_full;
  logic                  stk_ovf;
  logic                  stk_unf;

  modport master (
    output acc_sel, ld_ac, clr_ac, ac_in, push, pop,
    input  ac_out, zero_flag, neg_flag, stk_empty, stk_full, stk_ovf, stk_unf
  );

  modport slave (
    input  acc_sel, ld_ac, clr_ac, ac_in, push, pop,
    output ac_out, zero_flag, neg_flag, stk_empty, stk_full, stk_ovf, stk_unf
  );
endinterface

// File: rtl/accumulator_bank.sv
// Bank of NUM_ACC accumulators with an optional save/restore stack.
// Define ACC_STACK_EN to build the stack; without it push/pop are ignored and
// the stack status outputs are tied to their idle values.
module accumulator_bank #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_ACC     = 4,
  parameter int SEL_W       = 2,
  parameter int STACK_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  accumulator_bank_if.slave bus
);

  genvar gi;

  logic [NUM_ACC*DATA_WIDTH-1:0] acc_flat;
  logic [DATA_WIDTH-1:0]         rd_val;
  logic                          acc_we;
  logic [DATA_WIDTH-1:0]         acc_d;
  logic                          pop_wr;
  logic [DATA_WIDTH-1:0]         top_val;

  // Read mux: an out-of-range select reads as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (bus.acc_sel == SEL_W'(i)) begin
        rd_val = acc_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.ac_out    = rd_val;
  assign bus.zero_flag = (rd_val == '0);
  assign bus.neg_flag  = rd_val[DATA_WIDTH-1];

  // Write source for the selected accumulator: clear beats pop beats load.
  always_comb begin
    acc_we = 1'b0;
    acc_d  = bus.ac_in;
    if (bus.clr_ac) begin
      acc_we = 1'b1;
      acc_d  = '0;
    end else if (pop_wr) begin
      acc_we = 1'b1;
      acc_d  = top_val;
    end else if (bus.ld_ac) begin
      acc_we = 1'b1;
    end
  end

  // One register per accumulator; no slot matches an out-of-range select.
  for (gi = 0; gi < NUM_ACC; gi++) begin : g_acc
    logic [DATA_WIDTH-1:0] acc_q;

    // Accumulator register update.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
      end else if (acc_we && (bus.acc_sel == SEL_W'(gi))) begin
        acc_q <= acc_d;
      end
    end

    assign acc_flat[gi*DATA_WIDTH +: DATA_WIDTH] = acc_q;
  end

`ifdef ACC_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [SP_W-1:0]                   sp_q, sp_d;
  logic                              ovf_q, ovf_d;
  logic                              unf_q, unf_d;
  logic [STACK_DEPTH*DATA_WIDTH-1:0] stk_flat;
  logic                              empty, full, xchg, stk_we;
  logic [SP_W-1:0]                   wr_idx;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == SP_W'(STACK_DEPTH));

  // Stack control. Push+pop on a non-empty stack swaps the accumulator with
  // the top slot and leaves sp alone; on an empty stack only the push acts.
  always_comb begin
    xchg   = bus.push && bus.pop && !empty;
    pop_wr = bus.pop && !empty;
    stk_we = xchg || (bus.push && !full);
    wr_idx = xchg ? (sp_q - SP_W'(1)) : sp_q;
    sp_d   = sp_q;
    if (xchg) begin
      sp_d = sp_q;
    end else if (bus.push && !full) begin
      sp_d = sp_q + SP_W'(1);
    end else if (bus.pop && !empty) begin
      sp_d = sp_q - SP_W'(1);
    end
    ovf_d = ovf_q | (bus.push && !bus.pop && full);
    unf_d = unf_q | (bus.pop && !bus.push && empty);
  end

  // Top-of-stack read for pop and exchange.
  always_comb begin
    top_val = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) begin
        top_val = stk_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack slots hold only saved data, so they need no reset.
  for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stk
    logic [DATA_WIDTH-1:0] slot_q;

    // Save the pre-edge selected accumulator into the addressed slot.
    always_ff @(posedge clk) begin
      if (!rst && stk_we && (wr_idx == SP_W'(gi))) begin
        slot_q <= rd_val;
      end
    end

    assign stk_flat[gi*DATA_WIDTH +: DATA_WIDTH] = slot_q;
  end

  assign bus.stk_empty = empty;
  assign bus.stk_full  = full;
  assign bus.stk_ovf   = ovf_q;
  assign bus.stk_unf   = unf_q;
`else
  wire unused_stk_ops = bus.push ^ bus.pop;

  assign pop_wr        = 1'b0;
  assign top_val       = '0;
  assign bus.stk_empty = 1'b1;
  assign bus.stk_full  = 1'b0;
  assign bus.stk_ovf   = 1'b0;
  assign bus.stk_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_bank.sv
// Bench for accumulator_bank (DATA_WIDTH=8, NUM_ACC=4, STACK_DEPTH=2).
// Expected values come from a queue-based model; stack behaviour follows
// whether ACC_STACK_EN is defined for the build.
module tb_accumulator_bank;
  localparam int DW = 8;
  localparam int NA = 4;
  localparam int SW = 2;
  localparam int SD = 2;
`ifdef ACC_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  accumulator_bank_if #(.DATA_WIDTH(DW), .SEL_W(SW)) bif ();

  accumulator_bank #(
    .DATA_WIDTH(DW), .NUM_ACC(NA), .SEL_W(SW), .STACK_DEPTH(SD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  logic [7:0] m_acc[NA];
  logic [7:0] m_stk[$];
  bit         m_ovf, m_unf;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) m_acc[i] = 8'h00;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input int sel, input bit ld, input bit clr,
                            input logic [7:0] din, input bit psh, input bit pp);
    logic [7:0] cur;
    logic [7:0] popv;
    bit popped;
    popped = 1'b0;
    popv   = 8'h00;
    cur    = (sel < NA) ? m_acc[sel] : 8'h00;
    if (STK_EN) begin
      if (psh && pp && m_stk.size() > 0) begin
        popv = m_stk[m_stk.size()-1];
        m_stk[m_stk.size()-1] = cur;
        popped = 1'b1;
      end else if (psh) begin
        if (m_stk.size() < SD) m_stk.push_back(cur);
        else m_ovf = 1'b1;
      end else if (pp) begin
        if (m_stk.size() > 0) begin
          popv = m_stk.pop_back();
          popped = 1'b1;
        end else begin
          m_unf = 1'b1;
        end
      end
    end
    if (sel < NA) begin
      if (clr) m_acc[sel] = 8'h00;
      else if (popped) m_acc[sel] = popv;
      else if (ld) m_acc[sel] = din;
    end
  endtask

  // Read every accumulator back through the select mux, then the stack flags.
  task automatic check_all(input string tag);
    logic [SW-1:0] saved;
    saved = bif.acc_sel;
    for (int s = 0; s < NA; s++) begin
      bif.acc_sel = SW'(s);
      #1;
      cmp({tag, "/ac_out"}, bif.ac_out, m_acc[s]);
      cmp({tag, "/zero"}, {7'd0, bif.zero_flag}, {7'd0, m_acc[s] == 8'h00});
      cmp({tag, "/neg"}, {7'd0, bif.neg_flag}, {7'd0, m_acc[s][7]});
    end
    cmp({tag, "/empty"}, {7'd0, bif.stk_empty}, {7'd0, m_stk.size() == 0});
    cmp({tag, "/full"}, {7'd0, bif.stk_full}, {7'd0, m_stk.size() == SD});
    cmp({tag, "/ovf"}, {7'd0, bif.stk_ovf}, {7'd0, m_ovf});
    cmp({tag, "/unf"}, {7'd0, bif.stk_unf}, {7'd0, m_unf});
    bif.acc_sel = saved;
    #1;
  endtask

  task automatic idle_inputs();
    bif.ld_ac  = 1'b0;
    bif.clr_ac = 1'b0;
    bif.ac_in  = 8'h00;
    bif.push   = 1'b0;
    bif.pop    = 1'b0;
  endtask

  task automatic op(input string tag, input int sel, input bit ld, input bit clr,
                    input logic [7:0] din, input bit psh, input bit pp);
    bif.acc_sel = SW'(sel);
    bif.ld_ac   = ld;
    bif.clr_ac  = clr;
    bif.ac_in   = din;
    bif.push    = psh;
    bif.pop     = pp;
    @(posedge clk);
    model_step(sel, ld, clr, din, psh, pp);
    #1;
    idle_inputs();
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input bit psh, input bit ld, input logic [7:0] din);
    rst       = 1'b1;
    bif.push  = psh;
    bif.ld_ac = ld;
    bif.ac_in = din;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    idle_inputs();
    check_all(tag);
  endtask

  initial begin
    bif.acc_sel = '0;
    idle_inputs();
    model_reset();

    // Reset state: all accumulators zero, stack empty.
    do_reset("reset", 1'b0, 1'b0, 8'h00);
    for (int s = 0; s < NA; s++) begin
      bif.acc_sel = SW'(s);
      #1;
      cmp("reset_sweep_ac", bif.ac_out, 8'h00);
      cmp("reset_sweep_zero", {7'd0, bif.zero_flag}, 8'h01);
    end
    cmp("reset_empty", {7'd0, bif.stk_empty}, 8'h01);

    // Load only when ld_ac is high; other accumulators undisturbed.
    op("ld_off", 1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    cmp("ld_off_ac1", bif.ac_out, 8'h00);
    op("ld_on", 1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    cmp("ld_on_ac1", bif.ac_out, 8'hFF);
    cmp("ld_on_neg", {7'd0, bif.neg_flag}, 8'h01);
    op("ld_acc2", 2, 1'b1, 1'b0, 8'hCC, 1'b0, 1'b0);
    bif.acc_sel = SW'(1);
    #1;
    cmp("acc1_kept", bif.ac_out, 8'hFF);

    // Fill and overflow the stack, then restore.
    op("acc0_aa", 0, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    op("push1", 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op("push2", 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op("push3", 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cmp("push3_full", {7'd0, bif.stk_full}, {7'd0, STK_EN});
    cmp("push3_ovf", {7'd0, bif.stk_ovf}, {7'd0, STK_EN});
    op("acc0_11", 0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    op("pop1", 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cmp("pop1_ac0", bif.ac_out, STK_EN ? 8'hAA : 8'h11);

    // Drain to empty, then underflow; reset clears the sticky flags.
    op("pop2", 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    op("pop3", 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cmp("pop3_unf", {7'd0, bif.stk_unf}, {7'd0, STK_EN});
    do_reset("err_clear", 1'b0, 1'b0, 8'h00);
    cmp("err_clear_ovf", {7'd0, bif.stk_ovf}, 8'h00);
    cmp("err_clear_unf", {7'd0, bif.stk_unf}, 8'h00);

    // Exchange, check the saved top, then clear+pop.
    op("acc3_33", 3, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    op("push33", 3, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op("acc3_55", 3, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    op("xchg", 3, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cmp("xchg_ac3", bif.ac_out, STK_EN ? 8'h33 : 8'h55);
    op("pop_to2", 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    op("repush2", 2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op("clr_pop", 3, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    cmp("clr_pop_ac3", bif.ac_out, 8'h00);

    // Reset wins over a same-cycle push and load.
    op("pre_rst_ld", 1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0);
    do_reset("rst_override", 1'b1, 1'b1, 8'h77);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset("rnd_rst", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      end else begin
        op("rnd", int'($urandom_range(0, NA - 1)),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0,
           8'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
